xor_share_sched: RTL and testbench

//   Round-robin scheduler that time-shares one external switch-level my_xor

---
 rtl/xor_share_sched.sv | 189 ++++++++++++++++++
 tb/tb_xor_share_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_share_sched.sv
// -----------------------------------------------------------------------------
// xor_share_sched
//   Round-robin scheduler that time-shares one external switch-level XOR cell
//   among N_REQ requesters. One requester is granted at a time. Its operand
//   bits are latched onto the shared gate and held for SETTLE_CYC cycles so
//   the switch network can settle. The gate output is then captured and
//   returned with a one-cycle done pulse, and priority rotates to the
//   requester after the one just served.
//
// Ports
//   clk_in    : clock, all state changes on the rising edge
//   rst_n_in  : synchronous active-low reset
//   req_in    : per-requester request level, held until done
//   a_in/b_in : per-requester operand bits (bit i belongs to requester i)
//   gnt_out   : one-hot grant, zero when idle
//   done_out  : one-cycle pulse on the bit of the requester whose result
//               is on res_out
//   res_out   : last captured XOR result, held until the next capture
//   busy_out  : high while operands are driven onto the shared gate
//   xa_out    : to shared gate input a
//   xb_out    : to shared gate input b
//   xf_in     : from shared gate output
// -----------------------------------------------------------------------------
module xor_share_sched #(
    parameter int N_REQ      = 4,
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 4
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [N_REQ-1:0] req_in,
    input  logic [N_REQ-1:0] a_in,
    input  logic [N_REQ-1:0] b_in,
    output logic [N_REQ-1:0] gnt_out,
    output logic [N_REQ-1:0] done_out,
    output logic             res_out,
    output logic             busy_out,
    output logic             xa_out,
    output logic             xb_out,
    input  logic             xf_in
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q,   ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [N_REQ-1:0] gnt_q,   gnt_d;
    logic [N_REQ-1:0] done_q,  done_d;
    logic             res_q,   res_d;
    logic             busy_q,  busy_d;
    logic             xa_q,    xa_d;
    logic             xb_q,    xb_d;

    // Round-robin search: first requester at or after ptr_q, wrapping.
    // The loop runs from the farthest candidate back to ptr_q so the
    // nearest asserted request is the last assignment and wins.
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no
        // path can leave it unassigned and infer a latch.
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr_q) + k) % N_REQ);
            if (req_in[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Priority after the current owner, wrapping N_REQ-1 -> 0.
    logic [IDX_W-1:0] ptr_after_owner;
    assign ptr_after_owner = (owner_q == IDX_LAST) ? '0 : owner_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = '0;            // done is a single-cycle pulse
        res_d   = res_q;
        busy_d  = busy_q;
        xa_d    = xa_q;
        xb_d    = xb_q;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_DRIVE;
                    owner_d = win_idx;
                    cnt_d   = '0;
                    gnt_d   = ONE_HOT0 << win_idx;
                    busy_d  = 1'b1;
                    // Operands are sampled once here; later changes on
                    // a_in/b_in do not disturb the settling gate.
                    xa_d    = a_in[win_idx];
                    xb_d    = b_in[win_idx];
                end
            end

            ST_DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    // Settle time has elapsed: capture even if the request
                    // dropped on this very edge.
                    state_d         = ST_IDLE;
                    ptr_d           = ptr_after_owner;
                    cnt_d           = '0;
                    gnt_d           = '0;
                    busy_d          = 1'b0;
                    xa_d            = 1'b0;
                    xb_d            = 1'b0;
                    res_d           = xf_in;
                    done_d[owner_q] = 1'b1;
                end else if (!req_in[owner_q]) begin
                    // Requester withdrew before capture: drop silently,
                    // res_out keeps its previous value.
                    state_d = ST_IDLE;
                    ptr_d   = ptr_after_owner;
                    cnt_d   = '0;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    xa_d    = 1'b0;
                    xb_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                xa_d    = 1'b0;
                xb_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            res_q   <= 1'b0;
            busy_q  <= 1'b0;
            xa_q    <= 1'b0;
            xb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            xa_q    <= xa_d;
            xb_q    <= xb_d;
        end
    end

    assign gnt_out  = gnt_q;
    assign done_out = done_q;
    assign res_out  = res_q;
    assign busy_out = busy_q;
    assign xa_out   = xa_q;
    assign xb_out   = xb_q;

endmodule

// File: tb/tb_xor_share_sched.sv
// -----------------------------------------------------------------------------
// tb_xor_share_sched
//   Self-checking bench for xor_share_sched (N_REQ=4, SETTLE_CYC=2). The
//   shared switch-level XOR is stood in for by a behavioural XOR on
//   xa_out/xb_out. A transaction-level reference model (grant cycle number,
//   latched operands, rotating pointer) predicts every output each cycle;
//   directed phases cover reset, single request, truth table, fairness,
//   abort and reset mid-transaction, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_xor_share_sched;

    localparam int N_REQ      = 4;
    localparam int SETTLE_CYC = 2;
    localparam int CNT_W      = 4;

    logic             clk_in = 1'b0;
    logic             rst_n_in;
    logic [N_REQ-1:0] req_in;
    logic [N_REQ-1:0] a_in;
    logic [N_REQ-1:0] b_in;
    logic [N_REQ-1:0] gnt_out;
    logic [N_REQ-1:0] done_out;
    logic             res_out;
    logic             busy_out;
    logic             xa_out;
    logic             xb_out;
    logic             xf_in;

    always #5 clk_in = ~clk_in;

    // Shared gate stand-in.
    assign xf_in = xa_out ^ xb_out;

    xor_share_sched #(
        .N_REQ      (N_REQ),
        .SETTLE_CYC (SETTLE_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .req_in   (req_in),
        .a_in     (a_in),
        .b_in     (b_in),
        .gnt_out  (gnt_out),
        .done_out (done_out),
        .res_out  (res_out),
        .busy_out (busy_out),
        .xa_out   (xa_out),
        .xb_out   (xb_out),
        .xf_in    (xf_in)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int               cyc      = 0;   // rising edges seen
    bit               m_active = 0;
    int               m_owner  = 0;
    int               m_gcyc   = 0;   // edge number at which grant was issued
    int               m_ptr    = 0;
    bit               m_a      = 0;
    bit               m_b      = 0;
    bit               m_res    = 0;
    logic [N_REQ-1:0] m_done   = '0;

    task automatic model_step();
        int idx;
        cyc++;
        m_done = '0;
        if (!rst_n_in) begin
            m_active = 0;
            m_ptr    = 0;
            m_res    = 0;
        end else if (m_active) begin
            if (cyc - m_gcyc == SETTLE_CYC) begin
                m_res            = m_a ^ m_b;
                m_done[m_owner]  = 1'b1;
                m_active         = 0;
                m_ptr            = (m_owner + 1) % N_REQ;
            end else if (!req_in[m_owner]) begin
                m_active = 0;
                m_ptr    = (m_owner + 1) % N_REQ;
            end
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = (m_ptr + k) % N_REQ;
                if (req_in[idx] && !m_active) begin
                    m_active = 1;
                    m_owner  = idx;
                    m_gcyc   = cyc;
                    m_a      = a_in[idx];
                    m_b      = b_in[idx];
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [N_REQ-1:0] eg;
        eg = m_active ? (N_REQ'(1) << m_owner) : '0;
        check("gnt",         32'(gnt_out),  32'(eg));
        check("done",        32'(done_out), 32'(m_done));
        check("res",         32'(res_out),  32'(m_res));
        check("busy",        32'(busy_out), 32'(m_active));
        check("xa",          32'(xa_out),   32'(m_active & m_a));
        check("xb",          32'(xb_out),   32'(m_active & m_b));
        check("gnt_onehot0", 32'($onehot0(gnt_out)),  32'(1));
        check("done_onehot0",32'($onehot0(done_out)), 32'(1));
    endtask

    // One clock: model advances on the same edge as the DUT, outputs are
    // compared 1 time unit later; inputs are changed afterwards by callers.
    task automatic tick();
        @(posedge clk_in);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        req_in   = '0;
        tick();
        rst_n_in = 1'b1;
    endtask

    function automatic int gnt_index(input logic [N_REQ-1:0] g);
        int r;
        r = -1;
        for (int i = 0; i < N_REQ; i++) if (g[i]) r = i;
        return r;
    endfunction

    int tt_exp [4] = '{0, 1, 1, 0};

    initial begin
        bit               seen;
        int               ng;
        int               last_start;
        logic [N_REQ-1:0] prev_gnt;

        rst_n_in = 1'b0;
        req_in   = 4'b1111;
        a_in     = '0;
        b_in     = '0;

        // 1 Reset held 3 cycles with all requests asserted.
        repeat (3) begin
            tick();
            check("rst_gnt",  32'(gnt_out),  32'(0));
            check("rst_busy", 32'(busy_out), 32'(0));
        end
        rst_n_in = 1'b1;
        tick();
        check("first_gnt_after_rst", 32'(gnt_out), 32'(4'b0001));
        repeat (3) tick();

        // 2 Single request from requester 2, a=1 b=0.
        do_reset();
        req_in = 4'b0100;
        a_in   = 4'b0100;
        b_in   = 4'b0000;
        tick();
        check("single_gnt_c1", 32'(gnt_out), 32'(4'b0100));
        tick();
        check("single_no_done_c2", 32'(done_out), 32'(0));
        tick();
        check("single_done_c3", 32'(done_out), 32'(4'b0100));
        check("single_res_c3",  32'(res_out),  32'(1));
        req_in = '0;
        tick();
        tick();
        check("single_idle", 32'(gnt_out | {3'b0, busy_out}), 32'(0));

        // 3 Truth table on requester 1.
        for (int p = 0; p < 4; p++) begin
            a_in   = {2'b00, 1'(p >> 1), 1'b0};
            b_in   = {2'b00, 1'(p & 1), 1'b0};
            req_in = 4'b0010;
            seen   = 0;
            for (int c = 0; c < 10 && !seen; c++) begin
                tick();
                if (done_out[1]) begin
                    seen = 1;
                    check("tt_res", 32'(res_out), 32'(tt_exp[p]));
                end
            end
            check("tt_done_seen", 32'(seen), 32'(1));
            req_in = '0;
            tick();
        end

        // 4 Fairness with all requests held.
        do_reset();
        req_in     = 4'b1111;
        ng         = 0;
        last_start = 0;
        prev_gnt   = '0;
        for (int c = 0; c < 60 && ng < 12; c++) begin
            a_in = N_REQ'($urandom);
            b_in = N_REQ'($urandom);
            tick();
            if (gnt_out != 0 && prev_gnt == 0) begin
                check("fair_order", 32'(gnt_index(gnt_out)), 32'(ng % N_REQ));
                if (ng > 0) check("fair_spacing", 32'(cyc - last_start), 32'(SETTLE_CYC + 1));
                last_start = cyc;
                ng++;
            end
            prev_gnt = gnt_out;
        end
        check("fair_count", 32'(ng), 32'(12));
        req_in = '0;
        repeat (4) tick();

        // 5 Abort by requester 3; res_out must keep the earlier result.
        do_reset();
        req_in = 4'b0100;
        a_in   = 4'b0100;
        b_in   = 4'b0000;
        repeat (3) tick();
        check("abort_pre_res", 32'(res_out), 32'(1));
        req_in = 4'b1000;
        a_in   = 4'b1000;
        b_in   = 4'b1000;
        tick();
        check("abort_gnt3", 32'(gnt_out), 32'(4'b1000));
        req_in = 4'b0011;
        tick();
        check("abort_gnt_clr", 32'(gnt_out),  32'(0));
        check("abort_no_done", 32'(done_out), 32'(0));
        check("abort_res_kept",32'(res_out),  32'(1));
        req_in = 4'b0001;
        a_in   = 4'b0000;
        b_in   = 4'b0000;
        tick();
        check("abort_next_from_ptr0", 32'(gnt_out), 32'(4'b0001));
        repeat (2) tick();
        check("abort_next_done", 32'(done_out), 32'(4'b0001));
        req_in = '0;
        tick();

        // 6 Reset one cycle after a grant.
        do_reset();
        req_in = 4'b0010;
        repeat (3) tick();                // requester 1 served, ptr -> 2
        req_in = 4'b0000;
        tick();
        req_in = 4'b0010;
        tick();
        check("rstmid_gnt1", 32'(gnt_out), 32'(4'b0010));
        rst_n_in = 1'b0;
        tick();
        check("rstmid_gnt",  32'(gnt_out),  32'(0));
        check("rstmid_done", 32'(done_out), 32'(0));
        check("rstmid_busy", 32'(busy_out), 32'(0));
        rst_n_in = 1'b1;
        req_in   = 4'b0011;
        tick();
        check("rstmid_ptr0", 32'(gnt_out), 32'(4'b0001));
        req_in = '0;
        repeat (4) tick();

        // 7 Randomized traffic with occasional request drops and resets.
        req_in = '0;
        for (int c = 0; c < 400; c++) begin
            rst_n_in = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 3) == 0) req_in = req_in ^ N_REQ'($urandom);
            a_in = N_REQ'($urandom);
            b_in = N_REQ'($urandom);
            tick();
        end
        rst_n_in = 1'b1;
        req_in   = '0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
